ahb_lite_sram_slave: RTL and testbench

AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

---
 rtl/ahb_lite_sram_pkg.sv | 27 ++
 rtl/ahb_lite_sram_array.sv | 31 +++
 rtl/ahb_lite_sram_slave.sv | 157 +++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_sram_pkg.sv
// Shared AHB-Lite encodings and slave state type for the SRAM slave.
// Holds the transfer-type, transfer-size and response codes used by the slave and its bench.
package ahb_lite_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } slave_state_e;

endpackage

// File: rtl/ahb_lite_sram_array.sv
// Word-organised storage with per-byte synchronous write enables and a combinational read port.
// Contents have no reset so they survive bus resets.
module ahb_lite_sram_array
    import ahb_lite_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                          clk,
    input  logic [$clog2(MEM_DEPTH)-1:0]  idx,
    input  logic [DATA_WIDTH/BYTE_W-1:0]  be,
    input  logic [DATA_WIDTH-1:0]         wdata,
    output logic [DATA_WIDTH-1:0]         rdata
);

    localparam int BYTES = DATA_WIDTH / BYTE_W;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Byte-lane write into the addressed word
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (be[b]) begin
                mem_q[idx][BYTE_W*b +: BYTE_W] <= wdata[BYTE_W*b +: BYTE_W];
            end
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, two-cycle ERROR response, byte-lane writes.
// Data phase of an OKAY transfer finishes in ST_IDLE with dp_active_q set, which allows back-to-back pipelining.
module ahb_lite_sram_slave
    import ahb_lite_sram_pkg::*;
#(
    parameter int          DATA_WIDTH  = 32,
    parameter int          MEM_DEPTH   = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int          BYTES     = DATA_WIDTH / BYTE_W;
    localparam int          LANE_W    = $clog2(BYTES);
    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH * BYTES);
    localparam logic [2:0]  MAX_SIZE  = (DATA_WIDTH == 64) ? HSIZE_DWORD : HSIZE_WORD;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    function automatic logic [BYTES-1:0] lane_mask(input logic [2:0] size, input logic [LANE_W-1:0] lane);
        logic [BYTES-1:0] m;
        int               first;
        int               last;
        first = int'(lane);
        last  = first + int'(32'd1 << size);
        for (int b = 0; b < BYTES; b++) begin
            m[b] = (b >= first) && (b < last);
        end
        return m;
    endfunction

    slave_state_e          state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  dp_active_q, dp_active_d;
    logic                  dp_write_q, dp_write_d;
    logic [IDX_W-1:0]      dp_idx_q, dp_idx_d;
    logic [BYTES-1:0]      dp_be_q, dp_be_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;

    logic [32:0]           diff_s;
    logic                  capture_s;
    logic                  xfer_err_s;
    logic [IDX_W-1:0]      idx_s;
    logic [BYTES-1:0]      sram_we_s;
    logic [DATA_WIDTH-1:0] sram_rdata_s;
    logic                  final_cycle_s;
    logic                  unused_ok_s;

    assign unused_ok_s = &{1'b0, HBURST, HPROT, HMASTLOCK};

    // A 33-bit difference makes addresses below BASE_ADDR wrap to huge values and fail the range check
    assign diff_s     = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign idx_s      = IDX_W'(diff_s[31:0] >> LANE_W);
    assign xfer_err_s = (diff_s >= MEM_BYTES) || (HSIZE > MAX_SIZE)
                        || ((HADDR & ((32'd1 << HSIZE) - 32'd1)) != 32'd0);
    assign capture_s  = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ))
                        && ((state_q == ST_IDLE) || (state_q == ST_ERR2));

    assign final_cycle_s = (state_q == ST_IDLE) && dp_active_q;
    assign sram_we_s     = (final_cycle_s && dp_write_q) ? dp_be_q : '0;
    assign HRDATA        = (final_cycle_s && !dp_write_q) ? sram_rdata_s : '0;
    assign HREADYOUT     = hreadyout_q;
    assign HRESP         = hresp_q;

    // Next-state, data-phase bookkeeping and registered response
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        dp_active_d = dp_active_q;
        dp_write_d  = dp_write_q;
        dp_idx_d    = dp_idx_q;
        dp_be_d     = dp_be_q;
        case (state_q)
            ST_IDLE: dp_active_d = 1'b0;
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: begin
                state_d     = ST_IDLE;
                dp_active_d = 1'b0;
            end
        endcase
        if (capture_s && xfer_err_s) begin
            state_d     = ST_ERR1;
            dp_active_d = 1'b0;
            wait_cnt_d  = 4'd0;
        end else if (capture_s) begin
            dp_active_d = 1'b1;
            dp_write_d  = HWRITE;
            dp_idx_d    = idx_s;
            dp_be_d     = lane_mask(HSIZE, HADDR[LANE_W-1:0]);
            wait_cnt_d  = WAIT_LOAD;
            state_d     = (WAIT_STATES == 0) ? ST_IDLE : ST_WAIT;
        end else begin
            dp_idx_d = dp_idx_q;
        end
        hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    // State and response registers; reset aborts any in-flight transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            dp_active_q <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_idx_q    <= '0;
            dp_be_q     <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dp_active_q <= dp_active_d;
            dp_write_q  <= dp_write_d;
            dp_idx_q    <= dp_idx_d;
            dp_be_q     <= dp_be_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    ahb_lite_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (HCLK),
        .idx   (dp_idx_q),
        .be    (sram_we_s),
        .wdata (HWDATA),
        .rdata (sram_rdata_s)
    );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: two instances (0 and 2 wait states) on a shared stimulus bus,
// checked every cycle against a transaction-level model of the bus protocol and a byte-array memory.
module tb_ahb_lite_sram_slave;
    import ahb_lite_sram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        hsel_bus;
    int          sel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hsel0, hsel1;
    logic        ro0, ro1, rsp0, rsp1;
    logic [31:0] rd0, rd1;

    assign hsel0 = hsel_bus && (sel == 0);
    assign hsel1 = hsel_bus && (sel == 1);

    ahb_lite_sram_slave #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(ro0),
        .HWDATA(hwdata), .HREADYOUT(ro0), .HRESP(rsp0), .HRDATA(rd0));

    ahb_lite_sram_slave #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(3'b000), .HPROT(4'b0011), .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(ro1),
        .HWDATA(hwdata), .HREADYOUT(ro1), .HRESP(rsp1), .HRDATA(rd1));

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Model: byte memory per instance plus the current data phase of the selected instance
    logic [7:0]  mm [2][4096];
    int          dp_kind = 0;   // 0 none, 1 okay transfer, 2 error response
    int          dp_cnt  = 0;
    bit          dp_wr;
    logic [31:0] dp_addr;
    logic [2:0]  dp_size;
    logic [31:0] dp_data;

    logic        exp_ro = 1'b1, exp_rsp = 1'b0, exp_final_rd = 1'b0;
    logic [31:0] exp_rd = 32'h0;
    bit          chk_en = 1'b0;
    logic [31:0] rd_log [$];
    int          wait_log [$];
    int          low_run = 0;

    typedef struct {
        bit          hs;
        logic [1:0]  tr;
        bit          wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        int          gap;
    } txn_t;
    txn_t stim [$];

    task automatic add(input bit hs, input logic [1:0] tr, input bit wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] d, input int gap);
        txn_t t;
        t.hs = hs; t.tr = tr; t.wr = wr; t.sz = sz; t.a = a; t.d = d; t.gap = gap;
        stim.push_back(t);
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d, input int gap);
        add(1'b1, HTRANS_NONSEQ, 1'b1, sz, a, d, gap);
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz, input int gap);
        add(1'b1, HTRANS_NONSEQ, 1'b0, sz, a, 32'h0, gap);
    endtask

    function automatic logic [31:0] word_m(input int d, input logic [31:0] a);
        int b;
        b = int'({a[31:2], 2'b00});
        return {mm[d][b+3], mm[d][b+2], mm[d][b+1], mm[d][b]};
    endfunction

    task automatic expect_rd(input logic [31:0] lit, input string nm);
        logic [31:0] v;
        if (rd_log.size() == 0) begin
            check({nm, "_missing"}, 32'd0, 32'd1);
        end else begin
            v = rd_log.pop_front();
            check(nm, v, lit);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("hreadyout", (sel == 1) ? ro1 : ro0, exp_ro);
            check("hresp", (sel == 1) ? rsp1 : rsp0, exp_rsp);
            check("hrdata", (sel == 1) ? rd1 : rd0, exp_rd);
            check("idle_slave_ready", (sel == 1) ? ro0 : ro1, 1'b1);
            check("idle_slave_resp", (sel == 1) ? rsp0 : rsp1, 1'b0);
            check("idle_slave_rdata", (sel == 1) ? rd0 : rd1, 32'h0);
            if (exp_final_rd) begin
                rd_log.push_back((sel == 1) ? rd1 : rd0);
                wait_log.push_back(low_run);
            end
            if ((((sel == 1) ? ro1 : ro0) == 1'b0) && (((sel == 1) ? rsp1 : rsp0) == 1'b0))
                low_run++;
            else
                low_run = 0;
        end
    end

    task automatic drive_idle();
        hsel_bus = 1'b0; htrans = HTRANS_IDLE; haddr = 32'h0; hwrite = 1'b0; hsize = 3'b000;
        hwdata = 32'h0;
    endtask

    // Cycle-by-cycle driver and model update; entered and left at posedge+1
    task automatic run(input int max_cycles);
        int   cyc = 0;
        int   ws;
        bit   pres, fin;
        txn_t cur;
        ws = (sel == 1) ? 2 : 0;
        while ((stim.size() > 0 || dp_kind != 0) && cyc < max_cycles) begin
            exp_final_rd = 1'b0;
            exp_rd       = 32'h0;
            if (dp_kind == 1) begin
                exp_ro  = (dp_cnt >= ws);
                exp_rsp = 1'b0;
                if (dp_cnt >= ws && !dp_wr) begin
                    exp_rd       = word_m(sel, dp_addr);
                    exp_final_rd = 1'b1;
                end
            end else if (dp_kind == 2) begin
                exp_ro  = (dp_cnt >= 1);
                exp_rsp = 1'b1;
            end else begin
                exp_ro  = 1'b1;
                exp_rsp = 1'b0;
            end
            pres = 1'b0;
            if (stim.size() > 0 && exp_ro) begin
                if (stim[0].gap > 0) stim[0].gap = stim[0].gap - 1;
                else pres = 1'b1;
            end
            drive_idle();
            if (pres) begin
                cur = stim[0];
                hsel_bus = cur.hs; htrans = cur.tr; haddr = cur.a; hwrite = cur.wr; hsize = cur.sz;
            end
            if (dp_kind == 1 && dp_wr && dp_cnt >= ws) hwdata = dp_data;
            else hwdata = $urandom();
            chk_en = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            fin = (dp_kind == 0) || (dp_kind == 1 && dp_cnt >= ws) || (dp_kind == 2 && dp_cnt >= 1);
            if (dp_kind == 1 && fin && dp_wr) begin
                for (int b = 0; b < (1 << dp_size); b++)
                    mm[sel][dp_addr + b] = dp_data[8*((dp_addr + b) % 4) +: 8];
            end
            if (pres) void'(stim.pop_front());
            if (pres && cur.hs && cur.tr[1]) begin
                dp_kind = ((cur.a >= 32'd4096) || (cur.sz > 3'd2) || ((cur.a % (32'd1 << cur.sz)) != 0)) ? 2 : 1;
                dp_cnt  = 0;
                dp_wr   = cur.wr; dp_addr = cur.a; dp_size = cur.sz; dp_data = cur.d;
            end else if (fin) begin
                dp_kind = 0;
            end else begin
                dp_cnt++;
            end
        end
        check("run_completes", ((stim.size() > 0) || (dp_kind != 0)) ? 32'd1 : 32'd0, 32'd0);
        stim.delete();
        dp_kind = 0;
        drive_idle();
        exp_ro = 1'b1; exp_rsp = 1'b0; exp_rd = 32'h0; exp_final_rd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 0;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ready0", ro0, 1'b1);
        check("rst_resp0", rsp0, 1'b0);
        check("rst_rdata0", rd0, 32'h0);
        check("rst_ready1", ro1, 1'b1);
        check("rst_resp1", rsp1, 1'b0);
        check("rst_rdata1", rd1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero wait states
        rd_log.delete(); wait_log.delete();
        wr(32'h0, HSIZE_WORD, 32'hFFDDCCAA, 0);
        rd(32'h0, HSIZE_WORD, 0);
        wr(32'h8, HSIZE_WORD, 32'h01020304, 1);
        wr(32'hA, HSIZE_HALF, 32'hBEEF0000, 0);
        rd(32'h8, HSIZE_WORD, 0);
        rd(32'hA, HSIZE_WORD, 1);
        rd(32'h1000, HSIZE_WORD, 0);
        wr(32'h1000, HSIZE_WORD, 32'h12345678, 0);
        rd(32'h0, HSIZE_WORD, 0);
        rd(32'h10, HSIZE_DWORD, 1);
        add(1'b1, HTRANS_IDLE, 1'b1, HSIZE_WORD, 32'h0, 32'h0, 0);
        add(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h0, 32'h0, 0);
        add(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0, 32'h0, 0);
        rd(32'h0, HSIZE_WORD, 0);
        wr(32'hFFC, HSIZE_WORD, 32'h0BADC0DE, 0);
        rd(32'hFFC, HSIZE_WORD, 0);
        rd(32'h9, HSIZE_BYTE, 0);
        rd(32'hA, HSIZE_WORD, 0);
        rd(32'h8, HSIZE_WORD, 0);
        run(200);
        expect_rd(32'hFFDDCCAA, "ws0_write_then_read");
        expect_rd(32'hBEEF0304, "half_write_lanes");
        expect_rd(32'hFFDDCCAA, "oob_write_no_alias");
        expect_rd(32'hFFDDCCAA, "idle_busy_unsel_no_write");
        expect_rd(32'h0BADC0DE, "top_word_boundary");
        expect_rd(32'hBEEF0304, "byte_read_full_word");
        expect_rd(32'hBEEF0304, "capture_in_err2");
        check("ws0_no_wait", wait_log[0], 0);

        // Two wait states
        sel = 1;
        rd_log.delete(); wait_log.delete();
        wr(32'h4, HSIZE_WORD, 32'hA5A55A5A, 0);
        rd(32'h4, HSIZE_WORD, 0);
        wr(32'h0, HSIZE_WORD, 32'h11223344, 0);
        wr(32'h2, HSIZE_BYTE, 32'h00550000, 0);
        rd(32'h0, HSIZE_WORD, 0);
        rd(32'hA, HSIZE_WORD, 0);
        wr(32'h8, HSIZE_WORD, 32'hCAFEF00D, 1);
        rd(32'h8, HSIZE_WORD, 0);
        run(200);
        expect_rd(32'hA5A55A5A, "ws2_read");
        check("ws2_wait_cycles", wait_log[0], 2);
        expect_rd(32'h11553344, "byte_write_merge");
        expect_rd(32'hCAFEF00D, "ws2_pipelined_read");
        check("model_byte_merge", word_m(1, 32'h0), 32'h11553344);

        // Reset in the middle of a waited write
        chk_en   = 1'b0;
        hsel_bus = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h4; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge clk);
        #1;
        drive_idle();
        hwdata = 32'hDEADBEEF;
        check("wait_before_reset", ro1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_wait_rst_ready", ro1, 1'b1);
        check("mid_wait_rst_resp", rsp1, 1'b0);
        check("mid_wait_rst_rdata", rd1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_log.delete(); wait_log.delete();
        rd(32'h4, HSIZE_WORD, 0);
        run(50);
        expect_rd(32'hA5A55A5A, "reset_drops_write");

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
